// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps key press/release events onto NVOICES oscillator
// voices, preferring a retrigger, then a free voice, then stealing the oldest one.
module voice_allocator #(
   parameter int NVOICES = 4,
   parameter int INC_W   = 18,
   parameter int AGE_W   = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     key_valid,
   input  logic                     key_on,
   input  logic [3:0]               key_num,
   output logic                     key_ready,
   input  logic                     all_off,
   output logic [NVOICES-1:0]       voice_gate,
   output logic [NVOICES*INC_W-1:0] voice_inc,
   output logic [NVOICES*4-1:0]     voice_key,
   output logic                     steal
);
   localparam int IDX_W = $clog2(NVOICES);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SEARCH = 2'd1;
   localparam logic [1:0] ST_COMMIT = 2'd2;
   localparam logic [AGE_W-1:0] AGE_MAX = '1;

   logic [1:0]         state_q, state_d;
   logic               key_ready_q, key_ready_d;
   logic               ev_on_q, ev_on_d;
   logic [3:0]         ev_key_q, ev_key_d;
   logic [IDX_W-1:0]   tgt_q, tgt_d;
   logic               steal_pend_q, steal_pend_d;
   logic               steal_q, steal_d;
   logic [NVOICES-1:0] gate_q, gate_d;
   logic [INC_W-1:0]   inc_q [NVOICES];
   logic [INC_W-1:0]   inc_d [NVOICES];
   logic [3:0]         key_q [NVOICES];
   logic [3:0]         key_d [NVOICES];
   logic [AGE_W-1:0]   age_q [NVOICES];
   logic [AGE_W-1:0]   age_d [NVOICES];

   logic               hit_found, free_found;
   logic [IDX_W-1:0]   hit_idx, free_idx, old_idx;
   logic [AGE_W-1:0]   old_age;

   // Equal-tempered increments for one octave; the upper octave is a left shift.
   function automatic logic [INC_W-1:0] key_inc(input logic [3:0] k);
      logic [3:0]  idx;
      logic [14:0] base;
      idx = (k >= 4'd12) ? k - 4'd12 : k;
      case (idx)
         4'd0:    base = 15'd8779;
         4'd1:    base = 15'd9301;
         4'd2:    base = 15'd9854;
         4'd3:    base = 15'd10440;
         4'd4:    base = 15'd11060;
         4'd5:    base = 15'd11718;
         4'd6:    base = 15'd12415;
         4'd7:    base = 15'd13153;
         4'd8:    base = 15'd13935;
         4'd9:    base = 15'd14764;
         4'd10:   base = 15'd15642;
         default: base = 15'd16572;
      endcase
      key_inc = INC_W'(base);
      if (k >= 4'd12) key_inc = key_inc << 1;
   endfunction

   // Candidate voices for the latched key; ties on age resolve to the lowest index.
   // NOTE: combinational blocks use blocking '=' so later loop iterations see earlier results.
   always_comb begin
      hit_found  = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      old_idx    = '0;
      old_age    = age_q[0];
      for (int v = 0; v < NVOICES; v++) begin
         if (!hit_found && gate_q[v] && key_q[v] == ev_key_q) begin
            hit_found = 1'b1;
            hit_idx   = IDX_W'(v);
         end
         if (!free_found && !gate_q[v]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(v);
         end
         if (age_q[v] > old_age) begin
            old_age = age_q[v];
            old_idx = IDX_W'(v);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      ev_on_d      = ev_on_q;
      ev_key_d     = ev_key_q;
      tgt_d        = tgt_q;
      steal_pend_d = steal_pend_q;
      steal_d      = 1'b0;
      gate_d       = gate_q;
      inc_d        = inc_q;
      key_d        = key_q;
      age_d        = age_q;
      case (state_q)
         ST_IDLE: begin
            if (key_valid && key_ready_q) begin
               state_d  = ST_SEARCH;
               ev_on_d  = key_on;
               ev_key_d = key_num;
            end
         end
         ST_SEARCH: begin
            state_d      = ST_COMMIT;
            steal_pend_d = 1'b0;
            if (hit_found) begin
               tgt_d = hit_idx;
            end else if (free_found) begin
               tgt_d = free_idx;
            end else begin
               tgt_d        = old_idx;
               steal_pend_d = 1'b1;
            end
         end
         ST_COMMIT: begin
            state_d = ST_IDLE;
            if (ev_on_q) begin
               steal_d = steal_pend_q;
               for (int v = 0; v < NVOICES; v++) begin
                  if (v == int'(tgt_q)) begin
                     gate_d[v] = 1'b1;
                     key_d[v]  = ev_key_q;
                     inc_d[v]  = key_inc(ev_key_q);
                     age_d[v]  = '0;
                  end else if (gate_q[v] && age_q[v] != AGE_MAX) begin
                     age_d[v] = age_q[v] + 1'b1;
                  end
               end
            end else begin
               // Release only drops the gate; pitch and key stay for the release tail.
               for (int v = 0; v < NVOICES; v++) begin
                  if (gate_q[v] && key_q[v] == ev_key_q) gate_d[v] = 1'b0;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (all_off) begin
         state_d = ST_IDLE;
         steal_d = 1'b0;
         gate_d  = '0;
         for (int v = 0; v < NVOICES; v++) age_d[v] = '0;
      end
      key_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         key_ready_q  <= 1'b0;
         ev_on_q      <= 1'b0;
         ev_key_q     <= '0;
         tgt_q        <= '0;
         steal_pend_q <= 1'b0;
         steal_q      <= 1'b0;
         gate_q       <= '0;
         // NOTE: the voice arrays drive outputs and steer age-based stealing, so they are reset too.
         for (int v = 0; v < NVOICES; v++) begin
            inc_q[v] <= '0;
            key_q[v] <= '0;
            age_q[v] <= '0;
         end
      end else begin
         state_q      <= state_d;
         key_ready_q  <= key_ready_d;
         ev_on_q      <= ev_on_d;
         ev_key_q     <= ev_key_d;
         tgt_q        <= tgt_d;
         steal_pend_q <= steal_pend_d;
         steal_q      <= steal_d;
         gate_q       <= gate_d;
         inc_q        <= inc_d;
         key_q        <= key_d;
         age_q        <= age_d;
      end
   end

   for (genvar g = 0; g < NVOICES; g++) begin : g_pack
      assign voice_inc[g*INC_W +: INC_W] = inc_q[g];
      assign voice_key[g*4 +: 4]         = key_q[g];
   end

   assign voice_gate = gate_q;
   assign key_ready  = key_ready_q;
   assign steal      = steal_q;

endmodule
